proc_io_bridge: RTL and testbench

PROC_IO_BRIDGE -- requirements
Module: proc_io_bridge

---
 rtl/io_fifo.sv | 76 +++++++
 rtl/proc_io_bridge.sv | 155 +++++++++++++++
 tb/tb_proc_io_bridge.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : io_fifo
//  Purpose  : Single-clock FIFO for one processor input port. Pushes are
//             dropped while full, pops are dropped while empty, so the parent
//             can drive raw strobes without extra qualification.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             push, push_data     - write strobe and word
//             pop                 - read strobe (advances the head)
//             head_data           - current head entry (not gated by empty)
//             full, empty         - occupancy status, pure register decode
//  Revision : 1.0 - initial release
// ============================================================================
module io_fifo #(
  parameter int NUBITS = 16,
  parameter int FDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [NUBITS-1:0] push_data,
  input  logic              pop,
  output logic [NUBITS-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int c_PW = $clog2(FDEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FDEPTH);

  logic [NUBITS-1:0] r_mem [FDEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Status comes straight from the count register so that ready has no
  // combinational dependency on any strobe.
  assign full      = (r_count == c_DEPTH);
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign head_data = r_mem[r_rd_ptr];

  // Pointers are log2(FDEPTH) wide, so wrap modulo FDEPTH is implicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/proc_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : proc_io_bridge
//  Purpose  : Connects a simple processor I/O bus to NUIOIN streaming input
//             ports (each buffered by an io_fifo) and NUIOOU streaming output
//             ports (each a one-word holding register with valid bit).
//  Ports    : clk, rst                    - clock, async active-high reset
//             io_in, addr_in, req_in      - processor read path (io_in is
//                                           combinational head of FIFO)
//             io_out, addr_out, out_en    - processor write path
//             itr                         - one-cycle "data arrived" pulse
//             ext_in_data/valid/ready     - input streams, port k at
//                                           bits [k*NUBITS +: NUBITS]
//             ext_out_data/valid/ready    - output streams
//             udf_err, ovf_err            - sticky underflow/overflow flags
//  Revision : 1.0 - initial release
// ============================================================================
module proc_io_bridge #(
  parameter int NUBITS = 16,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [NUBITS-1:0]          io_in,
  input  logic [$clog2(NUIOIN)-1:0]  addr_in,
  input  logic                       req_in,
  input  logic [NUBITS-1:0]          io_out,
  input  logic [$clog2(NUIOOU)-1:0]  addr_out,
  input  logic                       out_en,
  output logic                       itr,
  input  logic [NUIOIN*NUBITS-1:0]   ext_in_data,
  input  logic [NUIOIN-1:0]          ext_in_valid,
  output logic [NUIOIN-1:0]          ext_in_ready,
  output logic [NUIOOU*NUBITS-1:0]   ext_out_data,
  output logic [NUIOOU-1:0]          ext_out_valid,
  input  logic [NUIOOU-1:0]          ext_out_ready,
  output logic [NUIOIN-1:0]          udf_err,
  output logic [NUIOOU-1:0]          ovf_err
);

  logic [NUBITS-1:0]        w_head [NUIOIN];
  logic [NUIOIN-1:0]        w_full;
  logic [NUIOIN-1:0]        w_empty;
  logic [NUIOIN-1:0]        w_push;
  logic [NUIOIN-1:0]        w_pop;
  logic [NUIOIN-1:0]        w_udf_hit;
  logic [NUIOOU-1:0]        w_wr;
  logic                     w_addr_in_ok;
  logic                     w_addr_out_ok;

  logic                     r_itr;
  logic [NUIOIN-1:0]        r_udf;
  logic [NUIOOU*NUBITS-1:0] r_out_data;
  logic [NUIOOU-1:0]        r_out_valid;
  logic [NUIOOU-1:0]        r_ovf;

  // Non-power-of-two port counts leave unused address codes; those are inert.
  assign w_addr_in_ok  = (int'(addr_in) < NUIOIN);
  assign w_addr_out_ok = (int'(addr_out) < NUIOOU);

  // ---------------------------------------------------------------- inputs
  assign ext_in_ready = ~w_full;
  assign w_push       = ext_in_valid & ~w_full;

  generate
    for (genvar k = 0; k < NUIOIN; k++) begin : g_fifo
      io_fifo #(
        .NUBITS (NUBITS),
        .FDEPTH (FDEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push[k]),
        .push_data (ext_in_data[k*NUBITS +: NUBITS]),
        .pop       (w_pop[k]),
        .head_data (w_head[k]),
        .full      (w_full[k]),
        .empty     (w_empty[k])
      );
    end
  endgenerate

  // Read decode: a read of an empty FIFO is an underflow rather than a pop,
  // even if a push lands on the same FIFO in the same cycle.
  always_comb begin
    w_pop     = '0;
    w_udf_hit = '0;
    io_in     = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (w_addr_in_ok && (int'(addr_in) == k)) begin
        if (w_empty[k]) begin
          w_udf_hit[k] = req_in;
        end else begin
          w_pop[k] = req_in;
          io_in    = w_head[k];
        end
      end
    end
  end

  // A FIFO turns non-empty only through an accepted push while empty (no pop
  // can occur on an empty FIFO), so that is the arrival condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_itr <= 1'b0;
      r_udf <= '0;
    end else begin
      r_itr <= |(w_empty & w_push);
      r_udf <= r_udf | w_udf_hit;
    end
  end

  assign itr     = r_itr;
  assign udf_err = r_udf;

  // --------------------------------------------------------------- outputs
  always_comb begin
    w_wr = '0;
    for (int j = 0; j < NUIOOU; j++) begin
      if (w_addr_out_ok && (int'(addr_out) == j)) begin
        w_wr[j] = out_en;
      end
    end
  end

  // A write always wins over acceptance; it only counts as an overflow when
  // the word it replaces was still pending and not taken this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= '0;
      r_ovf       <= '0;
    end else begin
      for (int j = 0; j < NUIOOU; j++) begin
        if (w_wr[j]) begin
          r_out_data[j*NUBITS +: NUBITS] <= io_out;
          r_out_valid[j]                 <= 1'b1;
          if (r_out_valid[j] && !ext_out_ready[j]) begin
            r_ovf[j] <= 1'b1;
          end
        end else if (r_out_valid[j] && ext_out_ready[j]) begin
          r_out_valid[j] <= 1'b0;
        end
      end
    end
  end

  assign ext_out_data  = r_out_data;
  assign ext_out_valid = r_out_valid;
  assign ovf_err       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_proc_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proc_io_bridge
//  Purpose  : Self-checking bench for proc_io_bridge: directed scenarios with
//             literal expectations, then randomized traffic, all compared
//             every cycle against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_proc_io_bridge;

  localparam int NB  = 16;
  localparam int NI  = 3;
  localparam int NO  = 3;
  localparam int FD  = 4;
  localparam int AIW = $clog2(NI);
  localparam int AOW = $clog2(NO);

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     io_in;
  logic [AIW-1:0]    addr_in;
  logic              req_in;
  logic [NB-1:0]     io_out;
  logic [AOW-1:0]    addr_out;
  logic              out_en;
  logic              itr;
  logic [NI*NB-1:0]  ext_in_data;
  logic [NI-1:0]     ext_in_valid;
  logic [NI-1:0]     ext_in_ready;
  logic [NO*NB-1:0]  ext_out_data;
  logic [NO-1:0]     ext_out_valid;
  logic [NO-1:0]     ext_out_ready;
  logic [NI-1:0]     udf_err;
  logic [NO-1:0]     ovf_err;

  proc_io_bridge #(
    .NUBITS (NB),
    .NUIOIN (NI),
    .NUIOOU (NO),
    .FDEPTH (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .io_in         (io_in),
    .addr_in       (addr_in),
    .req_in        (req_in),
    .io_out        (io_out),
    .addr_out      (addr_out),
    .out_en        (out_en),
    .itr           (itr),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .udf_err       (udf_err),
    .ovf_err       (ovf_err)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------ reference model
  logic [NB-1:0] mq [NI][$];
  logic [NB-1:0] m_od [NO];
  logic [NO-1:0] m_ov;
  logic [NO-1:0] m_ovf;
  logic [NI-1:0] m_udf;
  logic          m_itr;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) mq[k].delete();
    for (int j = 0; j < NO; j++) m_od[j] = '0;
    m_ov  = '0;
    m_ovf = '0;
    m_udf = '0;
    m_itr = 1'b0;
  endtask

  task automatic check_model();
    logic [NB-1:0]    e_io;
    logic [NI-1:0]    e_rdy;
    logic [NO*NB-1:0] e_od;
    e_io = '0;
    if (int'(addr_in) < NI) begin
      if (mq[addr_in].size() > 0) e_io = mq[addr_in][0];
    end
    for (int k = 0; k < NI; k++) e_rdy[k] = (mq[k].size() < FD);
    for (int j = 0; j < NO; j++) e_od[j*NB +: NB] = m_od[j];
    chk("io_in",     64'(io_in),         64'(e_io));
    chk("in_ready",  64'(ext_in_ready),  64'(e_rdy));
    chk("itr",       64'(itr),           64'(m_itr));
    chk("out_data",  64'(ext_out_data),  64'(e_od));
    chk("out_valid", 64'(ext_out_valid), 64'(m_ov));
    chk("udf_err",   64'(udf_err),       64'(m_udf));
    chk("ovf_err",   64'(ovf_err),       64'(m_ovf));
  endtask

  // Advances the model by one clock edge using the inputs as they stand.
  task automatic update_model();
    logic [NI-1:0] was_empty;
    logic [NI-1:0] acc;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < NI; k++) begin
        was_empty[k] = (mq[k].size() == 0);
        acc[k]       = ext_in_valid[k] && (mq[k].size() < FD);
      end
      if (req_in && int'(addr_in) < NI) begin
        if (mq[addr_in].size() > 0) void'(mq[addr_in].pop_front());
        else m_udf[addr_in] = 1'b1;
      end
      for (int k = 0; k < NI; k++) begin
        if (acc[k]) mq[k].push_back(ext_in_data[k*NB +: NB]);
      end
      m_itr = |(was_empty & acc);
      for (int j = 0; j < NO; j++) begin
        if (out_en && int'(addr_out) == j) begin
          if (m_ov[j] && !ext_out_ready[j]) m_ovf[j] = 1'b1;
          m_od[j] = io_out;
          m_ov[j] = 1'b1;
        end else if (m_ov[j] && ext_out_ready[j]) begin
          m_ov[j] = 1'b0;
        end
      end
    end
  endtask

  // ------------------------------------------------------------ sequencing
  task automatic idle();
    addr_in       = '0;
    req_in        = 1'b0;
    io_out        = '0;
    addr_out      = '0;
    out_en        = 1'b0;
    ext_in_data   = '0;
    ext_in_valid  = '0;
    ext_out_ready = '0;
  endtask

  task automatic settle();
    #1;
    check_model();
  endtask

  task automatic tick();
    update_model();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    settle();
    chk("rst_ready",  64'(ext_in_ready),  64'h7);
    chk("rst_io_in",  64'(io_in),         64'h0);
    chk("rst_itr",    64'(itr),           64'h0);
    chk("rst_oval",   64'(ext_out_valid), 64'h0);
    chk("rst_odata",  64'(ext_out_data),  64'h0);
    tick();
    rst = 1'b0;
    settle();

    // Basic read-back on port 1.
    ext_in_valid = 3'b010; ext_in_data[NB +: NB] = 16'h1234; settle(); tick();
    ext_in_data[NB +: NB] = 16'h5678; settle();
    chk("rb_itr", 64'(itr), 64'h1);
    tick();
    ext_in_valid = '0; req_in = 1'b1; addr_in = 2'd1; settle();
    chk("rb_first", 64'(io_in), 64'h1234);
    tick(); settle();
    chk("rb_second", 64'(io_in), 64'h5678);
    tick(); req_in = 1'b0; settle();
    chk("rb_empty", 64'(io_in), 64'h0);

    // Fill, blocked push on full, wrap and underflow on port 0.
    addr_in = 2'd0;
    for (int i = 0; i < 4; i++) begin
      ext_in_valid = 3'b001; ext_in_data[0 +: NB] = 16'hA000 + 16'(i);
      settle(); tick();
    end
    req_in = 1'b1; ext_in_data[0 +: NB] = 16'hA004; settle();
    chk("full_ready", 64'(ext_in_ready[0]), 64'h0);
    chk("full_head",  64'(io_in),           64'hA000);
    tick(); req_in = 1'b0; settle();
    chk("ready_back", 64'(ext_in_ready[0]), 64'h1);
    tick();
    ext_in_valid = '0; req_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("wrap_read", 64'(io_in), (i < 4) ? 64'hA001 + 64'(i) : 64'h0);
      tick();
    end
    req_in = 1'b0; settle();
    chk("udf0", 64'(udf_err[0]), 64'h1);

    // Interrupt: two ports from empty in one cycle give one pulse.
    ext_in_valid = 3'b011; ext_in_data[0 +: NB] = 16'h0C01; ext_in_data[NB +: NB] = 16'h0C02;
    settle();
    chk("itr_pre", 64'(itr), 64'h0);
    tick(); ext_in_valid = '0; settle();
    chk("itr_pulse", 64'(itr), 64'h1);
    tick(); settle();
    chk("itr_once", 64'(itr), 64'h0);
    ext_in_valid = 3'b001; ext_in_data[0 +: NB] = 16'h0C03; settle(); tick();
    ext_in_valid = '0; settle();
    chk("itr_nonempty", 64'(itr), 64'h0);

    // Output backpressure and overflow on port 1.
    out_en = 1'b1; addr_out = 2'd1; io_out = 16'h00AA; settle(); tick();
    io_out = 16'h00BB; settle(); tick();
    out_en = 1'b0; settle();
    chk("ovf_data",  64'(ext_out_data[NB +: NB]), 64'h00BB);
    chk("ovf_flag",  64'(ovf_err[1]),             64'h1);
    ext_out_ready = 3'b010; settle(); tick(); settle();
    chk("ovf_accept", 64'(ext_out_valid[1]), 64'h0);

    // Write coinciding with acceptance on port 0.
    ext_out_ready = '0; out_en = 1'b1; addr_out = 2'd0; io_out = 16'h0011; settle(); tick();
    ext_out_ready = 3'b001; io_out = 16'h0022; settle(); tick();
    out_en = 1'b0; ext_out_ready = '0; settle();
    chk("wa_valid", 64'(ext_out_valid[0]),  64'h1);
    chk("wa_data",  64'(ext_out_data[0 +: NB]), 64'h0022);
    chk("wa_noerr", 64'(ovf_err[0]),        64'h0);

    // Asynchronous reset in the middle of a burst.
    addr_in = 2'd2;
    for (int i = 0; i < 3; i++) begin
      ext_in_valid = 3'b100; ext_in_data[2*NB +: NB] = 16'hD000 + 16'(i);
      out_en = (i == 2); addr_out = 2'd2; io_out = 16'h0EEE;
      settle(); tick();
    end
    idle(); addr_in = 2'd2; settle();
    chk("mid_head",  64'(io_in),            64'hD000);
    chk("mid_oval",  64'(ext_out_valid[2]), 64'h1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_io_in", 64'(io_in),         64'h0);
    chk("arst_ready", 64'(ext_in_ready),  64'h7);
    chk("arst_oval",  64'(ext_out_valid), 64'h0);
    chk("arst_odata", 64'(ext_out_data),  64'h0);
    chk("arst_err",   64'({udf_err, ovf_err}), 64'h0);
    chk("arst_itr",   64'(itr),           64'h0);
    tick();
    rst = 1'b0; settle();
    chk("post_itr", 64'(itr), 64'h0);

    // Randomized traffic, including out-of-range addresses and rare resets.
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (rst) model_reset();
      for (int k = 0; k < NI; k++) begin
        ext_in_valid[k]        = ($urandom_range(0, 9) < 5);
        ext_in_data[k*NB +: NB] = NB'($urandom());
      end
      req_in        = ($urandom_range(0, 9) < 4);
      addr_in       = AIW'($urandom_range(0, 3));
      out_en        = ($urandom_range(0, 9) < 4);
      addr_out      = AOW'($urandom_range(0, 3));
      io_out        = NB'($urandom());
      ext_out_ready = NO'($urandom());
      settle();
      tick();
    end
    rst = 1'b0;
    idle();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
